// File: rtl/decoder_grant_arbiter_if.sv
// Requester/decoder handshake bundle for decoder_grant_arbiter.
// Latency: n/a (wiring only). Backpressure: none; grants are held until done, request drop or timeout.
// Ports: req/done from requesters; grant_en/grant_idx/grant/timeout/busy toward the select decoder.
interface decoder_grant_arbiter_if;
  logic [15:0] req;
  logic        done;
  logic        grant_en;
  logic [3:0]  grant_idx;
  logic [15:0] grant;
  logic        timeout;
  logic        busy;

  // Requester side drives req/done and observes the grant.
  modport master (
    output req, done,
    input  grant_en, grant_idx, grant, timeout, busy
  );

  // Arbiter side.
  modport slave (
    input  req, done,
    output grant_en, grant_idx, grant, timeout, busy
  );
endinterface

// File: rtl/decoder_grant_arbiter.sv
// Round-robin arbiter sharing one 4-to-16 one-hot select among 16 requesters.
// Latency: grant visible one cycle after req is sampled in IDLE/GAP; one dead GAP cycle between owners.
// Backpressure: owner holds until done, its req drops, or MAX_HOLD cycles elapse (timeout pulse).
// Ports: clk, rst_n (async active-low), bus (slave modport: req, done in; grant_en, grant_idx,
//        grant, timeout, busy out). All outputs are registered.
module decoder_grant_arbiter #(
  parameter int unsigned MAX_HOLD = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  decoder_grant_arbiter_if.slave bus
);

  // Last counter value allowed before a forced release.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  ptr;
  logic [7:0]  hold_cnt;
  logic        grant_en_q;
  logic [3:0]  grant_idx_q;
  logic [15:0] grant_q;
  logic        timeout_q;
  logic        busy_q;

  // Rotating search starting at ptr+1. Iterating from the far end down lets the
  // closest set bit overwrite earlier hits; offset 16 wraps to ptr itself, so the
  // previous owner is considered last.
  logic        win_vld;
  logic [3:0]  win_idx;
  logic [3:0]  cand;

  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr;
    cand    = '0;
    for (int i = 16; i >= 1; i--) begin
      cand = ptr + 4'(i);
      if (bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  logic owner_req;
  logic hold_expired;

  assign owner_req    = bus.req[grant_idx_q];
  assign hold_expired = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 4'd15;
      hold_cnt    <= '0;
      grant_en_q  <= 1'b0;
      grant_idx_q <= '0;
      grant_q     <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (win_vld) begin
            state       <= GRANT;
            ptr         <= win_idx;
            grant_idx_q <= win_idx;
            grant_en_q  <= 1'b1;
            grant_q     <= 16'(1) << win_idx;
            hold_cnt    <= '0;
            busy_q      <= 1'b1;
          end else begin
            state      <= IDLE;
            grant_en_q <= 1'b0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
          end
        end
        GRANT: begin
          if (bus.done || !owner_req || hold_expired) begin
            state      <= GAP;
            grant_en_q <= 1'b0;
            grant_q    <= '0;
            busy_q     <= 1'b1;
            // Explicit or implicit release takes precedence over the timeout.
            timeout_q  <= hold_expired && !bus.done && owner_req;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state      <= IDLE;
          grant_en_q <= 1'b0;
          grant_q    <= '0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant_en  = grant_en_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.grant     = grant_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Self-checking bench for decoder_grant_arbiter (MAX_HOLD = 4).
// Latency: one vector per clock; expectations are queued when driven and popped after the edge.
// Backpressure: n/a; covers rotation, wrap, timeout, done/timeout collision, implicit release, async reset.
module tb_decoder_grant_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  decoder_grant_arbiter_if bus ();

  decoder_grant_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic        en;
    logic [3:0]  idx;
    logic [15:0] gnt;
    logic        to;
    logic        busy;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic [15:0] r, input logic d, input logic en,
                              input logic [3:0] idx, input logic to, input logic busy);
    vec_t v;
    v.req  = r;
    v.done = d;
    v.en   = en;
    v.idx  = idx;
    v.gnt  = en ? (16'h0001 << idx) : 16'h0000;
    v.to   = to;
    v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input vec_t e);
    chk({tag, ".grant_en"},  32'(bus.grant_en),  32'(e.en));
    chk({tag, ".grant_idx"}, 32'(bus.grant_idx), 32'(e.idx));
    chk({tag, ".grant"},     32'(bus.grant),     32'(e.gnt));
    chk({tag, ".timeout"},   32'(bus.timeout),   32'(e.to));
    chk({tag, ".busy"},      32'(bus.busy),      32'(e.busy));
  endtask

  // Drive one vector, clock it, then compare against the queued expectation.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    bus.req  = v.req;
    bus.done = v.done;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      chk_outs(tag, e);
    end
  endtask

  initial begin
    bus.req  = '0;
    bus.done = 1'b0;

    // Directed table; each entry is the input before an edge and the outputs after it.
    // Single request at edge 2; done coincides with the 4-cycle timeout edge.
    tbl.push_back(mk(16'h0000, 0, 0, 4'd0,  0, 0));
    tbl.push_back(mk(16'h0020, 0, 1, 4'd5,  0, 1));
    tbl.push_back(mk(16'h0020, 0, 1, 4'd5,  0, 1));
    tbl.push_back(mk(16'h0020, 0, 1, 4'd5,  0, 1));
    tbl.push_back(mk(16'h0020, 0, 1, 4'd5,  0, 1));
    tbl.push_back(mk(16'h0020, 1, 0, 4'd5,  0, 1));
    tbl.push_back(mk(16'h0000, 0, 0, 4'd5,  0, 0));
    // Owner drops req mid-grant: GAP, no timeout.
    tbl.push_back(mk(16'h0100, 0, 1, 4'd8,  0, 1));
    tbl.push_back(mk(16'h0100, 0, 1, 4'd8,  0, 1));
    tbl.push_back(mk(16'h0000, 0, 0, 4'd8,  0, 1));
    tbl.push_back(mk(16'h0000, 0, 0, 4'd8,  0, 0));
    // Timeout: four visible grant cycles, pulse in GAP, re-grant to 3.
    tbl.push_back(mk(16'h0008, 0, 1, 4'd3,  0, 1));
    tbl.push_back(mk(16'h0008, 0, 1, 4'd3,  0, 1));
    tbl.push_back(mk(16'h0008, 0, 1, 4'd3,  0, 1));
    tbl.push_back(mk(16'h0008, 0, 1, 4'd3,  0, 1));
    tbl.push_back(mk(16'h0008, 0, 0, 4'd3,  1, 1));
    tbl.push_back(mk(16'h0008, 0, 1, 4'd3,  0, 1));
    tbl.push_back(mk(16'h0000, 0, 0, 4'd3,  0, 1));
    tbl.push_back(mk(16'h0000, 0, 0, 4'd3,  0, 0));
    // Wrap: owner 14 releases with 16'h4003 pending -> 0, 1, 14.
    tbl.push_back(mk(16'h4000, 0, 1, 4'd14, 0, 1));
    tbl.push_back(mk(16'h4003, 1, 0, 4'd14, 0, 1));
    tbl.push_back(mk(16'h4003, 0, 1, 4'd0,  0, 1));
    tbl.push_back(mk(16'h4003, 1, 0, 4'd0,  0, 1));
    tbl.push_back(mk(16'h4003, 0, 1, 4'd1,  0, 1));
    tbl.push_back(mk(16'h4003, 1, 0, 4'd1,  0, 1));
    tbl.push_back(mk(16'h4003, 0, 1, 4'd14, 0, 1));
    tbl.push_back(mk(16'h4003, 1, 0, 4'd14, 0, 1));
    tbl.push_back(mk(16'h0000, 0, 0, 4'd14, 0, 0));
    // done outside GRANT has no effect.
    tbl.push_back(mk(16'h0000, 1, 0, 4'd14, 0, 0));

    // Reset values while rst_n is held low.
    #2;
    chk_outs("reset", mk(16'h0000, 0, 0, 4'd0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("v%0d", i));
    end

    // Asynchronous reset between edges while grant = 16'h0100.
    step(mk(16'h0100, 0, 1, 4'd8, 0, 1), "pre_arst");
    #3 rst_n = 1'b0;
    #1;
    chk_outs("arst_now", mk(16'h0000, 0, 0, 4'd0, 0, 0));
    @(posedge clk);
    #1;
    chk_outs("arst_hold", mk(16'h0000, 0, 0, 4'd0, 0, 0));
    #2 rst_n = 1'b1;

    // Full rotation after reset: 0..15 then 0, one zero-grant cycle between owners.
    step(mk(16'hFFFF, 0, 1, 4'd0, 0, 1), "rot_first");
    for (int i = 0; i < 16; i++) begin
      step(mk(16'hFFFF, 1, 0, 4'(i), 0, 1), $sformatf("rot_gap%0d", i));
      step(mk(16'hFFFF, 0, 1, 4'((i + 1) % 16), 0, 1), $sformatf("rot_gnt%0d", (i + 1) % 16));
    end
    step(mk(16'h0000, 1, 0, 4'd0, 0, 1), "rot_rel");
    step(mk(16'h0000, 0, 0, 4'd0, 0, 0), "rot_idle");

    if (sb_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_grant_arbiter.md
# decoder_grant_arbiter

Round-robin arbiter that shares one 4-to-16 one-hot select resource among 16 requesters. It picks one requester at a time, drives the decoder-style index/enable pair and the matching one-hot grant vector, and holds the grant until the owner signals done or a hold timeout expires. It sits between the requesting agents and the 16-line select decoder, so the select outputs are glitch-free, registered and never multi-hot.

## Interface
- `MAX_HOLD`, default 255: maximum cycles a grant may be held before forced release. Legal range 1..255.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  16  request vector; bit i high means requester i wants the resource.
- `done`  in  1  one-cycle pulse from the current owner releasing the grant. Ignored outside GRANT.
- `grant_en`  out  1  decoder enable; high exactly while a grant is held.
- `grant_idx`  out  4  index of the current owner. Holds its last value when `grant_en` is low.
- `grant`  out  16  one-hot grant, equal to `1 << grant_idx` when `grant_en` is high; otherwise all zero.
- `timeout`  out  1  one-cycle pulse marking a forced release.
- `busy`  out  1  high in GRANT and GAP.

## Operation
- States:
  - IDLE: no owner; arbitrate every cycle.
  - GRANT: owner holds the resource.
  - GAP: one dead cycle, `grant` all zero; arbitrate.
- Arbitration is performed in IDLE and GAP:
  - Search `req` starting at index `ptr+1` and wrap modulo 16.
  - The first set bit wins: load it into `grant_idx`, set `ptr` to the winner, go to GRANT.
  - If `req` is zero: IDLE stays in IDLE, GAP goes to IDLE.
- GRANT exit:
  - `done` high: go to GAP.
  - Owner's `req` bit low: go to GAP (implicit release).
  - Hold counter reaches `MAX_HOLD-1` with neither condition: go to GAP and pulse `timeout`.
  - If `done` and timeout coincide, `done` wins and no `timeout` pulse is issued.
- Hold counter:
  - 8-bit, cleared on entry to GRANT, increments each GRANT cycle, saturates.
- Fairness:
  - A requester that just released is last in priority on the next arbitration.
  - Any continuously asserted request is granted within 15 intervening grants.
- Requests from non-owners during GRANT are ignored; they are sampled only when arbitration runs.
- Output rules:
  - `grant` is decoded from registered `grant_idx` and `grant_en` only, never directly from `req`.
  - `grant` is never multi-hot.
  - `grant` is all zero for at least one full cycle between any two owners, including back-to-back grants to different requesters.

## Timing
- Reset values:
  - state IDLE, `ptr` = 15 (so requester 0 has first priority), hold counter 0.
  - `grant_en` 0, `grant_idx` 0, `grant` 0, `timeout` 0, `busy` 0.
- Asynchronous reset mid-grant drops `grant` and `grant_en` immediately, without waiting for a clock edge.
- Grant latency:
  - `req` sampled high at edge t in IDLE gives `grant_en`/`grant` high after edge t.
  - These are visible in the cycle following that edge.
- Release:
  - `done` sampled at edge k drops `grant` after edge k.
  - GAP occupies cycle k..k+1; the next grant appears after edge k+1.
  - Minimum owner-to-owner gap is therefore one cycle.
- Timeout:
  - For a grant first visible after edge g, forced release occurs at edge `g+MAX_HOLD`.
  - `timeout` is high for the single cycle following that edge (GAP cycle).
- `busy` is registered and aligned with state.

## Test plan
- Reset then single request:
  - Stimulus: `rst_n` low, release, then `req`=16'h0020 at edge 2.
  - Required: `grant`=16'h0020 and `grant_idx`=5 after edge 2. `done` at edge 6 gives `grant`=0 after edge 6, and state returns to IDLE after edge 7.
- Round-robin rotation:
  - Stimulus: `req`=16'hFFFF held, `done` pulsed each grant.
  - Required: owners 0,1,2,…,15,0 in order, each separated by one zero-`grant` cycle.
- Wrap and priority:
  - Stimulus: owner 14 releases while `req`=16'h4003.
  - Required: next owner is 0, then 1, then 14.
- Timeout:
  - Stimulus: `MAX_HOLD`=4, `req`=16'h0008 held, no `done`.
  - Required: grant visible 4 cycles, forced release, one-cycle `timeout` pulse. Requester 3 is re-granted after the GAP.
- Simultaneous events:
  - Stimulus 1: `done` on the same cycle as the timeout edge.
    - Required: no `timeout` pulse.
  - Stimulus 2: owner drops `req` mid-grant.
    - Required: GAP next cycle, no `timeout` pulse.
- Asynchronous reset mid-grant:
  - Stimulus: `rst_n` low between clock edges while `grant`=16'h0100.
  - Required: `grant`, `grant_en` and `busy` go to 0 immediately. After reset release, `ptr`=15, so requester 0 wins if requested.
